// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared widths, defaults and FSM encoding for the bus arbiter
package bus_arbiter_pkg;

    localparam int INST_ADDR_BUS_W = 32;
    localparam int REG_BUS_W       = 32;
    localparam int WAIT_MAX_DEF    = 255;

    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IF    = 2'd1,
        ARB_MEM   = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/bus_wdt.sv
// rtl/bus_wdt.sv - bus wait counter; flags the last tolerated un-acked cycle of a transfer
module bus_wdt
    import bus_arbiter_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] cnt_q;

    // Fires in the WAIT_MAX-th waiting cycle so the request is high exactly WAIT_MAX cycles.
    assign expired = run && (cnt_q == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares one memory bus between instruction fetch and MEM-stage data access
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = INST_ADDR_BUS_W,
    parameter int DATA_W   = REG_BUS_W,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              if_stallreq_o,
    output logic              if_err_o,
    input  logic              flush_i,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_stallreq_o,
    output logic              mem_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    arb_state_e        state_q, state_d;
    logic              fbuf_valid_q;
    logic [ADDR_W-1:0] fbuf_addr_q;
    logic              if_done_q, mem_done_q;
    logic              fbuf_hit;
    logic              start_if, start_mem;
    logic              if_fin, mem_fin, if_abort, mem_abort;
    logic              wdt_run, wdt_clr, wdt_expired;

    assign fbuf_hit       = fbuf_valid_q && (fbuf_addr_q == if_addr_i);
    assign if_stallreq_o  = if_ce_i & ~fbuf_hit & ~if_done_q;
    assign mem_stallreq_o = mem_ce_i & ~mem_done_q;

    assign wdt_run = (state_q != ARB_IDLE) && !bus_ack_i;
    assign wdt_clr = (state_d == ARB_IDLE);

    bus_wdt #(.WAIT_MAX(WAIT_MAX)) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdt_clr),
        .run     (wdt_run),
        .expired (wdt_expired)
    );

    always_comb begin
        state_d   = state_q;
        start_if  = 1'b0;
        start_mem = 1'b0;
        if_fin    = 1'b0;
        mem_fin   = 1'b0;
        if_abort  = 1'b0;
        mem_abort = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // MEM holds the older instruction, so it wins over IF.
                if (mem_ce_i && !mem_done_q) begin
                    start_mem = 1'b1;
                    state_d   = ARB_MEM;
                end else if (if_ce_i && !fbuf_hit && !if_done_q && !flush_i) begin
                    start_if = 1'b1;
                    state_d  = ARB_IF;
                end
            end
            ARB_IF: begin
                // A flush coinciding with completion discards the data like a drain would.
                if (bus_ack_i) begin
                    if_fin  = !flush_i;
                    state_d = ARB_IDLE;
                end else if (wdt_expired) begin
                    if_abort = !flush_i;
                    state_d  = ARB_IDLE;
                end else if (flush_i) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_MEM: begin
                if (bus_ack_i) begin
                    mem_fin = 1'b1;
                    state_d = ARB_IDLE;
                end else if (wdt_expired) begin
                    mem_abort = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end
            ARB_DRAIN: begin
                if (bus_ack_i || wdt_expired) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            fbuf_valid_q <= 1'b0;
            fbuf_addr_q  <= '0;
            if_done_q    <= 1'b0;
            mem_done_q   <= 1'b0;
            if_err_o     <= 1'b0;
            mem_err_o    <= 1'b0;
            if_inst_o    <= '0;
            mem_rdata_o  <= '0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_sel_o    <= '0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
        end else begin
            state_q    <= state_d;
            if_done_q  <= if_fin || if_abort;
            mem_done_q <= mem_fin || mem_abort;
            if_err_o   <= if_abort;
            mem_err_o  <= mem_abort;
            if (flush_i) begin
                fbuf_valid_q <= 1'b0;
            end
            if (if_fin) begin
                if_inst_o    <= bus_rdata_i;
                fbuf_addr_q  <= bus_addr_o;
                fbuf_valid_q <= 1'b1;
            end
            if (if_abort) begin
                if_inst_o <= '0;
            end
            if (mem_fin) begin
                mem_rdata_o <= bus_rdata_i;
            end
            if (start_mem) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= mem_we_i;
                bus_sel_o   <= mem_sel_i;
                bus_addr_o  <= mem_addr_i;
                bus_wdata_o <= mem_wdata_i;
            end else if (start_if) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= 1'b0;
                bus_sel_o   <= SEL_WORD;
                bus_addr_o  <= if_addr_i;
                bus_wdata_o <= '0;
            end else if (state_q != ARB_IDLE && state_d == ARB_IDLE) begin
                bus_req_o   <= 1'b0;
                bus_we_o    <= 1'b0;
                bus_sel_o   <= '0;
                bus_addr_o  <= '0;
                bus_wdata_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter with a bus slave model and scoreboard
module tb_bus_arbiter;

    localparam logic [31:0] JUNK = 32'hBAD0BAD0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } bus_exp_t;

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_out;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i, flush_i, mem_ce_i, mem_we_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] if_inst_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
    logic        if_stallreq_o, if_err_o, mem_stallreq_o, mem_err_o;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    bus_exp_t exp_q[$];
    bus_exp_t cur;
    vec_t     vecs[6];
    int       n_cmp = 0;
    int       n_fail = 0;
    int       n_bus = 0;
    int       req_cycles = 0;
    logic     manual_ack = 1'b0;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o),
        .if_stallreq_o(if_stallreq_o), .if_err_o(if_err_o), .flush_i(flush_i),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .mem_stallreq_o(mem_stallreq_o), .mem_err_o(mem_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus slave + scoreboard: each new request pops the next expected transfer,
    // which also carries the response data and ack delay (0 = never ack).
    initial begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = JUNK;
        forever begin
            @(negedge clk);
            bus_ack_i   = 1'b0;
            bus_rdata_i = JUNK;
            if (bus_req_o) begin
                if (req_cycles == 0) begin
                    n_bus++;
                    check("bus_expected_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check("bus_addr", bus_addr_o, cur.addr);
                        check("bus_we", bus_we_o, cur.we);
                        check("bus_sel", bus_sel_o, cur.sel);
                        check("bus_wdata", bus_wdata_o, cur.wdata);
                    end else begin
                        cur = '{32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 0};
                    end
                end
                req_cycles++;
                if (cur.delay != 0 && req_cycles == cur.delay) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = cur.rdata;
                end
            end else begin
                req_cycles = 0;
            end
            if (manual_ack) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = 32'hCAFEF00D;
            end
        end
    end

    task automatic apply_vec(input vec_t v, input int idx);
        int cyc = 0;
        int nb;
        logic done = 1'b0;
        @(posedge clk); #1;
        nb = n_bus;
        if (v.is_mem) begin
            mem_ce_i = 1'b1; mem_we_i = v.we; mem_sel_i = v.sel;
            mem_addr_i = v.addr; mem_wdata_i = v.wdata;
            exp_q.push_back('{v.addr, v.we, v.sel, v.wdata, v.rdata, v.delay});
        end else begin
            if_ce_i = 1'b1; if_addr_i = v.addr;
            exp_q.push_back('{v.addr, 1'b0, 4'hF, 32'h0, v.rdata, v.delay});
        end
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (v.is_mem ? mem_stallreq_o : if_stallreq_o) cyc++;
            else done = 1'b1;
        end
        check($sformatf("vec%0d_done", idx), done, 1);
        check($sformatf("vec%0d_latency", idx), cyc, v.delay + 1);
        check($sformatf("vec%0d_out", idx), v.is_mem ? mem_rdata_o : if_inst_o, v.exp_out);
        check($sformatf("vec%0d_buscycles", idx), n_bus - nb, 1);
        if (v.is_mem) begin
            @(posedge clk); #1;
            mem_ce_i = 1'b0;
        end
    endtask

    initial begin
        int nb, nreq, nerr, ifseen_i, low_early;
        logic mem_seen, if_seen, drop;

        vecs[0] = '{1'b0, 1'b0, 4'hF,    32'h100,  32'h0,        32'h3C011234, 3, 32'h3C011234};
        vecs[1] = '{1'b1, 1'b0, 4'hF,    32'h2000, 32'h0,        32'h8C220004, 1, 32'h8C220004};
        vecs[2] = '{1'b1, 1'b1, 4'b0011, 32'h2004, 32'h0000BEEF, 32'h00000000, 2, 32'h00000000};
        vecs[3] = '{1'b0, 1'b0, 4'hF,    32'h0FC,  32'h0,        32'h24080005, 2, 32'h24080005};
        vecs[4] = '{1'b1, 1'b0, 4'b1000, 32'h2008, 32'h0,        32'hA5A5A5A5, 4, 32'hA5A5A5A5};
        vecs[5] = '{1'b0, 1'b0, 4'hF,    32'h104,  32'h0,        32'h20420001, 1, 32'h20420001};

        rst = 1'b1; if_ce_i = 1'b0; if_addr_i = 32'h0; flush_i = 1'b0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", bus_req_o, 0);
        check("rst_bus_we", bus_we_o, 0);
        check("rst_bus_sel", bus_sel_o, 0);
        check("rst_bus_addr", bus_addr_o, 0);
        check("rst_bus_wdata", bus_wdata_o, 0);
        check("rst_if_inst", if_inst_o, 0);
        check("rst_mem_rdata", mem_rdata_o, 0);
        check("rst_errs", {if_err_o, mem_err_o}, 0);
        check("rst_stalls", {if_stallreq_o, mem_stallreq_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

        // Held PC with a valid fetch buffer: no bus traffic, no stall.
        nb = n_bus;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_if_stall", if_stallreq_o, 0);
            check("hold_bus_req", bus_req_o, 0);
        end
        @(posedge clk); #1;
        check("hold_bus_count", n_bus - nb, 0);

        // Simultaneous requests: MEM goes first, IF stays stalled until its own fetch.
        if_addr_i = 32'h10C;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h2000; mem_wdata_i = 32'h0;
        exp_q.push_back('{32'h2000, 1'b0, 4'hF, 32'h0, 32'h12345678, 1});
        exp_q.push_back('{32'h10C, 1'b0, 4'hF, 32'h0, 32'h00000013, 2});
        mem_seen = 1'b0; if_seen = 1'b0; low_early = 0; ifseen_i = 0;
        for (int c = 0; c < 20 && !if_seen; c++) begin
            @(negedge clk);
            if (!mem_seen && !mem_stallreq_o) begin
                mem_seen = 1'b1;
                check("sim_mem_rdata", mem_rdata_o, 32'h12345678);
                check("sim_if_stall_at_mem_done", if_stallreq_o, 1);
            end else if (mem_seen && !if_stallreq_o) begin
                if_seen = 1'b1;
                ifseen_i = c;
                check("sim_if_inst", if_inst_o, 32'h00000013);
            end else if (!if_stallreq_o) begin
                low_early++;
            end
            @(posedge clk); #1;
            if (mem_seen) mem_ce_i = 1'b0;
        end
        check("sim_if_done", if_seen, 1);
        check("sim_if_done_cycle", ifseen_i, 5);
        check("sim_if_stall_low_early", low_early, 0);

        // Flush mid-fetch: drained data is discarded and the new PC is fetched next.
        @(posedge clk); #1;
        if_addr_i = 32'h180;
        exp_q.push_back('{32'h180, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 4});
        exp_q.push_back('{32'h200, 1'b0, 4'hF, 32'h0, 32'h00000093, 1});
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush_i = 1'b1; if_addr_i = 32'h200;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("flush_inst_kept", if_inst_o, 32'h00000013);
        check("flush_if_stall", if_stallreq_o, 1);
        if_seen = 1'b0;
        for (int c = 0; c < 20 && !if_seen; c++) begin
            @(negedge clk);
            if (!if_stallreq_o) if_seen = 1'b1;
        end
        check("flush_refetch_done", if_seen, 1);
        check("flush_refetch_inst", if_inst_o, 32'h00000093);

        // Never-acked store: request held exactly WAIT_MAX cycles, single error pulse.
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011; mem_addr_i = 32'h3000; mem_wdata_i = 32'h55AA;
        exp_q.push_back('{32'h3000, 1'b1, 4'b0011, 32'h55AA, 32'h0, 0});
        nreq = 0; nerr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_req_o) nreq++;
            if (mem_err_o) nerr++;
            if (if_err_o) nerr += 100;
            drop = !mem_stallreq_o;
            @(posedge clk); #1;
            if (drop) mem_ce_i = 1'b0;
        end
        check("tmo_req_cycles", nreq, 8);
        check("tmo_err_pulses", nerr, 1);
        @(negedge clk);
        check("tmo_idle_req", bus_req_o, 0);
        check("tmo_mem_stall", mem_stallreq_o, 0);

        // Reset in the middle of a load, then a late ack that must be ignored.
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h4000; mem_wdata_i = 32'h0;
        exp_q.push_back('{32'h4000, 1'b0, 4'hF, 32'h0, 32'h77777777, 0});
        @(posedge clk); #1;
        rst = 1'b1; if_ce_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; mem_ce_i = 1'b0; manual_ack = 1'b1;
        @(negedge clk);
        check("rstmid_bus_req", bus_req_o, 0);
        check("rstmid_bus_fields", {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 0);
        @(posedge clk); #1;
        manual_ack = 1'b0;
        @(negedge clk);
        check("rstmid_mem_rdata", mem_rdata_o, 0);
        check("rstmid_idle_req", bus_req_o, 0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
